// File: rtl/clic_pkg.sv
// Shared types for the CLIC interrupt arbiter: FSM states, default widths and
// the arbitration winner record.
package clic_pkg;

  localparam int unsigned ClicLevelWidth = 8;
  localparam int unsigned ClicIdWidth    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } clic_state_e;

  typedef struct packed {
    logic                      valid;
    logic [ClicIdWidth-1:0]    id;
    logic [ClicLevelWidth-1:0] level;
  } clic_win_t;

endpackage

// File: rtl/clic_irq_arbiter_max_tree.sv
// Log2-depth max tree over (valid, level, index); on equal levels the left
// (lower-index) operand wins at every node.
module clic_max_tree
  import clic_pkg::*;
#(
  parameter int unsigned NumSrc = 64
) (
  input  logic [NumSrc-1:0]                pend_i,
  input  logic [NumSrc*ClicLevelWidth-1:0] level_i,
  output clic_win_t                        win_o
);

  localparam int unsigned Depth  = $clog2(NumSrc);
  localparam int unsigned Leaves = 32'd1 << Depth;

  clic_win_t node_s [2*Leaves-1];

  // Heap-ordered tree: leaves at [Leaves-1 ..], node n has children 2n+1 / 2n+2.
  always_comb begin
    node_s = '{default: '0};
    for (int i = 0; i < int'(NumSrc); i++) begin
      node_s[int'(Leaves) - 1 + i] = {pend_i[i], ClicIdWidth'(i),
                                      level_i[i*ClicLevelWidth +: ClicLevelWidth]};
    end
    for (int n = int'(Leaves) - 2; n >= 0; n--) begin
      if (node_s[2*n+2].valid &&
          (!node_s[2*n+1].valid || (node_s[2*n+2].level > node_s[2*n+1].level))) begin
        node_s[n] = node_s[2*n+2];
      end else begin
        node_s[n] = node_s[2*n+1];
      end
    end
  end

  assign win_o = node_s[0];

endmodule

// File: rtl/clic_irq_arbiter.sv
// CLIC interrupt arbiter: edge/level pending capture, level-based selection and
// the request/ack handshake toward the core's one-hot irq port.
module clic_irq_arbiter
  import clic_pkg::*;
#(
  parameter int unsigned NumSrc     = 64,
  parameter int unsigned LevelWidth = ClicLevelWidth,
  parameter int unsigned IdWidth    = $clog2(NumSrc)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NumSrc-1:0]            src_i,
  input  logic [NumSrc-1:0]            ie_i,
  input  logic [NumSrc-1:0]            edge_i,
  input  logic [NumSrc*LevelWidth-1:0] level_i,
  output logic [NumSrc-1:0]            irq_o,
  output logic [LevelWidth-1:0]        irq_level_o,
  input  logic                         irq_ack_i,
  output logic [NumSrc-1:0]            src_ack_o,
  output logic                         busy_o
);

  logic [NumSrc-1:0]     src_q, edge_pend_q, edge_pend_d;
  logic [NumSrc-1:0]     set_s, clr_s, pend_s, eff_s, irq_d;
  logic [IdWidth-1:0]    id_q, id_d, win_id_s;
  logic [LevelWidth-1:0] lvl_q, lvl_d, win_lvl_s, irq_level_d;
  logic                  ack_fire_s, busy_d;
  clic_state_e           state_q, state_d;
  clic_win_t             win_s;

  clic_max_tree #(.NumSrc(NumSrc)) u_max_tree (
    .pend_i  (eff_s),
    .level_i (level_i),
    .win_o   (win_s)
  );

  assign win_id_s  = IdWidth'(win_s.id);
  assign win_lvl_s = LevelWidth'(win_s.level);

  // Pending capture; a new edge on the acked source outranks the ack clear.
  always_comb begin
    ack_fire_s = (state_q == REQ) & irq_ack_i;
    set_s      = src_i & ~src_q & edge_i;
    clr_s      = '0;
    if (ack_fire_s) begin
      clr_s[id_q] = 1'b1;
    end else begin
      clr_s = '0;
    end
    edge_pend_d = (edge_pend_q & ~clr_s) | set_s;
    pend_s      = (edge_i & edge_pend_q) | (~edge_i & src_i);
    eff_s       = pend_s & ie_i;
  end

  // Handshake FSM next state plus the next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    lvl_d     = lvl_q;
    src_ack_o = '0;
    case (state_q)
      IDLE: begin
        if (win_s.valid) begin
          state_d = REQ;
          id_d    = win_id_s;
          lvl_d   = win_lvl_s;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          src_ack_o[id_q] = 1'b1;
          state_d         = GAP;
        end else if (!eff_s[id_q]) begin
          state_d = GAP;
        end else if (win_s.valid && (win_lvl_s > lvl_q)) begin
          id_d  = win_id_s;
          lvl_d = win_lvl_s;
        end else begin
          state_d = REQ;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    irq_d       = '0;
    irq_level_d = '0;
    if (state_d == REQ) begin
      irq_d[id_d] = 1'b1;
      irq_level_d = lvl_d;
    end else begin
      irq_level_d = '0;
    end
    busy_d = (state_d != IDLE);
  end

  // State, pending and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      edge_pend_q <= '0;
      id_q        <= '0;
      lvl_q       <= '0;
      irq_o       <= '0;
      irq_level_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_i;
      edge_pend_q <= edge_pend_d;
      id_q        <= id_d;
      lvl_q       <= lvl_d;
      irq_o       <= irq_d;
      irq_level_o <= irq_level_d;
      busy_o      <= busy_d;
    end
  end

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// Directed bench for clic_irq_arbiter: per-cycle expectations queued and
// compared against the DUT outputs, plus a continuous one-hot-or-zero monitor.
module tb_clic_irq_arbiter;

  localparam int NS = 64;
  localparam int LW = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NS-1:0]    src, ie, edg;
  logic [NS*LW-1:0] lvl;
  logic             ack;
  logic [NS-1:0]    irq_o, src_ack_o;
  logic [LW-1:0]    irq_level_o;
  logic             busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          irq_id;
    logic [7:0]  lv;
    int          ack_id;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  clic_irq_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_i       (src),
    .ie_i        (ie),
    .edge_i      (edg),
    .level_i     (lvl),
    .irq_o       (irq_o),
    .irq_level_o (irq_level_o),
    .irq_ack_i   (ack),
    .src_ack_o   (src_ack_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [NS-1:0] oh(input int id);
    logic [NS-1:0] v;
    v = '0;
    if (id >= 0) v[id] = 1'b1;
    return v;
  endfunction

  task automatic setl(input int k, input logic [7:0] v);
    lvl[k*LW +: LW] = v;
  endtask

  // Queue the expectation for this cycle, compare it, then move to the next cycle.
  task automatic cyc(input string tag, input int irq_id, input logic [7:0] lv,
                     input int ack_id, input logic busy);
    exp_t e;
    e.tag = tag; e.irq_id = irq_id; e.lv = lv; e.ack_id = ack_id; e.busy = busy;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    checks++;
    assert (irq_o === oh(e.irq_id)) else begin
      errors++; $error("FAIL %s irq_o got %h exp %h", e.tag, irq_o, oh(e.irq_id));
    end
    checks++;
    assert (irq_level_o === e.lv) else begin
      errors++; $error("FAIL %s irq_level_o got %h exp %h", e.tag, irq_level_o, e.lv);
    end
    checks++;
    assert (src_ack_o === oh(e.ack_id)) else begin
      errors++; $error("FAIL %s src_ack_o got %h exp %h", e.tag, src_ack_o, oh(e.ack_id));
    end
    checks++;
    assert (busy_o === e.busy) else begin
      errors++; $error("FAIL %s busy_o got %b exp %b", e.tag, busy_o, e.busy);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    checks++;
    assert ($onehot0(irq_o)) else begin
      errors++; $error("FAIL onehot0 irq_o got %h exp at most one bit", irq_o);
    end
  end

  initial begin
    rst_n = 1'b1; src = '0; ie = '1; edg = '1; lvl = '0; ack = 1'b0;
    #1 rst_n = 1'b0;
    cyc("reset", -1, 8'h00, -1, 1'b0);
    rst_n = 1'b1;

    // single edge source, two-edge latency, ack, GAP+IDLE, ignored idle ack
    setl(5, 8'h20); src[5] = 1'b1;
    cyc("t1_rise", -1, 8'h00, -1, 1'b0);
    cyc("t1_lat", -1, 8'h00, -1, 1'b0);
    cyc("t1_req", 5, 8'h20, -1, 1'b1);
    ack = 1'b1;
    cyc("t1_ack", 5, 8'h20, 5, 1'b1);
    ack = 1'b0;
    cyc("t1_gap", -1, 8'h00, -1, 1'b1);
    cyc("t1_idle", -1, 8'h00, -1, 1'b0);
    ack = 1'b1;
    cyc("t1_idle_ack", -1, 8'h00, -1, 1'b0);
    ack = 1'b0; src[5] = 1'b0;
    cyc("t1_cleared", -1, 8'h00, -1, 1'b0);

    // equal levels: lower index first, then the other after GAP+IDLE
    setl(3, 8'h40); setl(9, 8'h40); src[3] = 1'b1; src[9] = 1'b1;
    cyc("t2_rise", -1, 8'h00, -1, 1'b0);
    cyc("t2_lat", -1, 8'h00, -1, 1'b0);
    cyc("t2_first", 3, 8'h40, -1, 1'b1);
    ack = 1'b1;
    cyc("t2_ack3", 3, 8'h40, 3, 1'b1);
    ack = 1'b0;
    cyc("t2_gap", -1, 8'h00, -1, 1'b1);
    cyc("t2_idle", -1, 8'h00, -1, 1'b0);
    cyc("t2_second", 9, 8'h40, -1, 1'b1);
    ack = 1'b1;
    cyc("t2_ack9", 9, 8'h40, 9, 1'b1);
    ack = 1'b0; src[3] = 1'b0; src[9] = 1'b0;
    cyc("t2_gap2", -1, 8'h00, -1, 1'b1);
    cyc("t2_idle2", -1, 8'h00, -1, 1'b0);

    // preemption by a higher level, none by an equal level
    setl(2, 8'h10); setl(7, 8'h80); src[2] = 1'b1;
    cyc("t3_rise2", -1, 8'h00, -1, 1'b0);
    cyc("t3_lat", -1, 8'h00, -1, 1'b0);
    cyc("t3_req2", 2, 8'h10, -1, 1'b1);
    src[7] = 1'b1;
    cyc("t3_rise7", 2, 8'h10, -1, 1'b1);
    cyc("t3_pend7", 2, 8'h10, -1, 1'b1);
    cyc("t3_preempt", 7, 8'h80, -1, 1'b1);
    ack = 1'b1; src[7] = 1'b0;
    cyc("t3_ack7", 7, 8'h80, 7, 1'b1);
    ack = 1'b0;
    cyc("t3_gap", -1, 8'h00, -1, 1'b1);
    cyc("t3_idle", -1, 8'h00, -1, 1'b0);
    cyc("t3_req2b", 2, 8'h10, -1, 1'b1);
    setl(7, 8'h10); src[7] = 1'b1;
    cyc("t3_eq_rise", 2, 8'h10, -1, 1'b1);
    cyc("t3_eq_hold1", 2, 8'h10, -1, 1'b1);
    cyc("t3_eq_hold2", 2, 8'h10, -1, 1'b1);
    ack = 1'b1;
    cyc("t3_ack2", 2, 8'h10, 2, 1'b1);
    ack = 1'b0;
    cyc("t3_gap2", -1, 8'h00, -1, 1'b1);
    cyc("t3_idle2", -1, 8'h00, -1, 1'b0);
    cyc("t3_req7", 7, 8'h10, -1, 1'b1);
    ack = 1'b1; src[2] = 1'b0; src[7] = 1'b0;
    cyc("t3_ack7b", 7, 8'h10, 7, 1'b1);
    ack = 1'b0;
    cyc("t3_gap3", -1, 8'h00, -1, 1'b1);
    cyc("t3_idle3", -1, 8'h00, -1, 1'b0);

    // level source: re-presented after ack, withdrawn by ie drop
    edg[4] = 1'b0; setl(4, 8'h30); src[4] = 1'b1;
    cyc("t4_rise", -1, 8'h00, -1, 1'b0);
    cyc("t4_req", 4, 8'h30, -1, 1'b1);
    ack = 1'b1;
    cyc("t4_ack", 4, 8'h30, 4, 1'b1);
    ack = 1'b0;
    cyc("t4_gap", -1, 8'h00, -1, 1'b1);
    cyc("t4_idle", -1, 8'h00, -1, 1'b0);
    cyc("t4_rereq", 4, 8'h30, -1, 1'b1);
    ie[4] = 1'b0;
    cyc("t4_ie_drop", 4, 8'h30, -1, 1'b1);
    cyc("t4_withdrawn", -1, 8'h00, -1, 1'b1);
    src[4] = 1'b0; ie[4] = 1'b1; edg[4] = 1'b1;
    cyc("t4_idle2", -1, 8'h00, -1, 1'b0);
    cyc("t4_quiet", -1, 8'h00, -1, 1'b0);

    // ack together with a higher arrival and a fresh edge on the acked source
    setl(1, 8'h20); setl(6, 8'h50); src[1] = 1'b1;
    cyc("t5_rise1", -1, 8'h00, -1, 1'b0);
    cyc("t5_lat", -1, 8'h00, -1, 1'b0);
    cyc("t5_req1", 1, 8'h20, -1, 1'b1);
    src[1] = 1'b0;
    cyc("t5_fall1", 1, 8'h20, -1, 1'b1);
    ack = 1'b1; src[1] = 1'b1; src[6] = 1'b1;
    cyc("t5_ack1", 1, 8'h20, 1, 1'b1);
    ack = 1'b0;
    cyc("t5_gap", -1, 8'h00, -1, 1'b1);
    cyc("t5_idle", -1, 8'h00, -1, 1'b0);
    cyc("t5_req6", 6, 8'h50, -1, 1'b1);
    ack = 1'b1;
    cyc("t5_ack6", 6, 8'h50, 6, 1'b1);
    ack = 1'b0;
    cyc("t5_gap2", -1, 8'h00, -1, 1'b1);
    cyc("t5_idle2", -1, 8'h00, -1, 1'b0);
    cyc("t5_req1_kept", 1, 8'h20, -1, 1'b1);
    ack = 1'b1;
    cyc("t5_ack1b", 1, 8'h20, 1, 1'b1);
    ack = 1'b0; src[1] = 1'b0; src[6] = 1'b0;
    cyc("t5_gap3", -1, 8'h00, -1, 1'b1);
    cyc("t5_idle3", -1, 8'h00, -1, 1'b0);
    cyc("t5_quiet", -1, 8'h00, -1, 1'b0);

    // asynchronous reset in the middle of a request
    setl(8, 8'h60); src[8] = 1'b1;
    cyc("t6_rise", -1, 8'h00, -1, 1'b0);
    cyc("t6_lat", -1, 8'h00, -1, 1'b0);
    cyc("t6_req", 8, 8'h60, -1, 1'b1);
    rst_n = 1'b0; ack = 1'b1;
    cyc("t6_rst", -1, 8'h00, -1, 1'b0);
    ack = 1'b0; src[8] = 1'b0;
    cyc("t6_rst_hold", -1, 8'h00, -1, 1'b0);
    rst_n = 1'b1;
    cyc("t6_release", -1, 8'h00, -1, 1'b0);
    cyc("t6_no_stale1", -1, 8'h00, -1, 1'b0);
    cyc("t6_no_stale2", -1, 8'h00, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
